// File: rtl/if_stage_if.sv
// Fetch-stage bus: control inputs, ROM fetch port and the IF/ID register outputs.
// The master modport is the fetch stage; the slave modport is its environment.
interface if_stage_if;
  logic        stall_if;
  logic        stall_id;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] inst_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        id_adel_o;

  modport master (
    input  stall_if, stall_id, flush, new_pc, branch_flag, branch_target, inst_i,
    output pc_o, ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o
  );

  modport slave (
    output stall_if, stall_id, flush, new_pc, branch_flag, branch_target, inst_i,
    input  pc_o, ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o
  );
endinterface

// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage: owns the PC, drives the instruction ROM and
// fills the IF/ID register with delay-slot-aware sequencing, stalls and flushes.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'h0000_0004
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);

  logic [31:0] pc_r;
  logic        ce_r;
  logic [31:0] id_pc_r;
  logic [31:0] id_inst_r;
  logic        id_valid_r;
  logic        id_adel_r;

  logic        stall_s;
  logic [31:0] pc_next_s;
  logic        adel_s;
  logic [31:0] inst_s;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Next-PC selection and the word to capture into IF/ID this cycle.
  always_comb begin
    // An ID stall alone is treated as a full stall so IF never overruns a held IF/ID.
    stall_s = bus.stall_if | bus.stall_id;
    adel_s  = ce_r & misaligned(pc_r);

    if (adel_s || !ce_r) begin
      inst_s = 32'h0000_0000;
    end else begin
      inst_s = bus.inst_i;
    end

    if (!ce_r) begin
      pc_next_s = pc_r;
    end else if (bus.flush) begin
      pc_next_s = bus.new_pc;
    end else if (stall_s) begin
      pc_next_s = pc_r;
    end else if (bus.branch_flag) begin
      // pc_r already points at the delay slot, which is captured on this same edge.
      pc_next_s = bus.branch_target;
    end else begin
      pc_next_s = pc_r + PC_STEP;
    end
  end

  // PC, fetch enable and IF/ID register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      ce_r       <= 1'b0;
      id_pc_r    <= 32'h0000_0000;
      id_inst_r  <= 32'h0000_0000;
      id_valid_r <= 1'b0;
      id_adel_r  <= 1'b0;
    end else begin
      ce_r <= 1'b1;
      pc_r <= pc_next_s;
      if (bus.flush) begin
        id_pc_r    <= 32'h0000_0000;
        id_inst_r  <= 32'h0000_0000;
        id_valid_r <= 1'b0;
        id_adel_r  <= 1'b0;
      end else if (bus.stall_id) begin
        id_pc_r    <= id_pc_r;
        id_inst_r  <= id_inst_r;
        id_valid_r <= id_valid_r;
        id_adel_r  <= id_adel_r;
      end else if (bus.stall_if) begin
        id_pc_r    <= 32'h0000_0000;
        id_inst_r  <= 32'h0000_0000;
        id_valid_r <= 1'b0;
        id_adel_r  <= 1'b0;
      end else begin
        id_pc_r    <= pc_r;
        id_inst_r  <= inst_s;
        id_valid_r <= ce_r;
        id_adel_r  <= adel_s;
      end
    end
  end

  assign bus.pc_o       = pc_r;
  assign bus.ce_o       = ce_r;
  assign bus.id_pc_o    = id_pc_r;
  assign bus.id_inst_o  = id_inst_r;
  assign bus.id_valid_o = id_valid_r;
  assign bus.id_adel_o  = id_adel_r;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run checked against
// a behavioural model of the fetch stage kept alongside the DUT.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  if_stage_if bus();

  if_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'h0000_0004)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h3401_0000 + (a >> 2) + 32'd1;
  endfunction

  assign bus.inst_i = rom(bus.pc_o);

  // Model state
  logic [31:0] m_pc, m_id_pc, m_id_inst;
  logic        m_ce, m_id_valid, m_id_adel;

  task automatic model_step();
    logic [31:0] cap_pc;
    logic        cap_ce;
    cap_pc = m_pc;
    cap_ce = m_ce;
    if (rst) begin
      m_pc = 32'h0; m_ce = 1'b0;
      m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0; m_id_adel = 1'b0;
    end else begin
      if (bus.flush || (bus.stall_if && !bus.stall_id)) begin
        m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0; m_id_adel = 1'b0;
      end else if (!bus.stall_id) begin
        m_id_pc    = cap_pc;
        m_id_valid = cap_ce;
        m_id_adel  = cap_ce && (cap_pc % 4 != 0);
        m_id_inst  = (cap_ce && cap_pc % 4 == 0) ? rom(cap_pc) : 32'h0;
      end
      if (cap_ce) begin
        if (bus.flush) m_pc = bus.new_pc;
        else if (!(bus.stall_if || bus.stall_id))
          m_pc = bus.branch_flag ? bus.branch_target : cap_pc + 32'd4;
      end
      m_ce = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall_if = 1'b0; bus.stall_id = 1'b0; bus.flush = 1'b0;
    bus.new_pc = 32'h0; bus.branch_flag = 1'b0; bus.branch_target = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    total++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", bus.pc_o, 32'h0); end
    total++; if (bus.ce_o !== 1'b0) begin bad++; $display("FAIL reset_ce: got %b want 0", bus.ce_o); end
    total++; if (bus.id_pc_o !== 32'h0 || bus.id_inst_o !== 32'h0) begin bad++;
      $display("FAIL reset_id: got pc %h inst %h want 0 0", bus.id_pc_o, bus.id_inst_o); end
    total++; if (bus.id_valid_o !== 1'b0 || bus.id_adel_o !== 1'b0) begin bad++;
      $display("FAIL reset_flags: got valid %b adel %b want 0 0", bus.id_valid_o, bus.id_adel_o); end
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    tick();
    total++; if (bus.ce_o !== 1'b1 || bus.pc_o !== 32'h0 || bus.id_valid_o !== 1'b0) begin bad++;
      $display("FAIL seq_start: got ce %b pc %h valid %b want 1 0 0", bus.ce_o, bus.pc_o, bus.id_valid_o); end
    tick();
    total++; if (bus.id_valid_o !== 1'b1 || bus.id_pc_o !== 32'h0 || bus.id_inst_o !== 32'h3401_0001) begin bad++;
      $display("FAIL seq_first: got valid %b pc %h inst %h want 1 0 34010001", bus.id_valid_o, bus.id_pc_o, bus.id_inst_o); end
    tick();
    total++; if (bus.id_pc_o !== 32'h4 || bus.id_inst_o !== 32'h3401_0002 || bus.pc_o !== 32'h8) begin bad++;
      $display("FAIL seq_second: got id_pc %h inst %h pc %h want 4 34010002 8", bus.id_pc_o, bus.id_inst_o, bus.pc_o); end
  endtask

  task automatic test_branch();
    bus.branch_flag = 1'b1; bus.branch_target = 32'h40;
    tick();
    bus.branch_flag = 1'b0;
    total++; if (bus.id_pc_o !== 32'h8 || bus.id_valid_o !== 1'b1 || bus.pc_o !== 32'h40) begin bad++;
      $display("FAIL branch_slot: got id_pc %h valid %b pc %h want 8 1 40", bus.id_pc_o, bus.id_valid_o, bus.pc_o); end
    tick();
    total++; if (bus.id_pc_o !== 32'h40 || bus.id_valid_o !== 1'b1) begin bad++;
      $display("FAIL branch_target: got id_pc %h valid %b want 40 1", bus.id_pc_o, bus.id_valid_o); end
  endtask

  task automatic test_stall();
    bus.flush = 1'b1; bus.new_pc = 32'h8;
    tick();
    bus.flush = 1'b0;
    tick();
    bus.stall_if = 1'b1; bus.stall_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.pc_o !== 32'hC || bus.id_pc_o !== 32'h8 || bus.id_valid_o !== 1'b1) begin bad++;
        $display("FAIL stall_hold%0d: got pc %h id_pc %h valid %b want c 8 1", i, bus.pc_o, bus.id_pc_o, bus.id_valid_o); end
    end
    bus.stall_if = 1'b0; bus.stall_id = 1'b0;
    tick(); tick();
    total++; if (bus.id_pc_o !== 32'h10 || bus.pc_o !== 32'h14) begin bad++;
      $display("FAIL stall_resume: got id_pc %h pc %h want 10 14", bus.id_pc_o, bus.pc_o); end
    bus.stall_if = 1'b1;
    tick();
    bus.stall_if = 1'b0;
    total++; if (bus.id_valid_o !== 1'b0 || bus.id_pc_o !== 32'h0 || bus.id_inst_o !== 32'h0 || bus.pc_o !== 32'h14) begin bad++;
      $display("FAIL stall_bubble: got valid %b id_pc %h inst %h pc %h want 0 0 0 14", bus.id_valid_o, bus.id_pc_o, bus.id_inst_o, bus.pc_o); end
    tick();
    total++; if (bus.id_pc_o !== 32'h14 || bus.id_valid_o !== 1'b1) begin bad++;
      $display("FAIL stall_after_bubble: got id_pc %h valid %b want 14 1", bus.id_pc_o, bus.id_valid_o); end
  endtask

  task automatic test_flush();
    bus.flush = 1'b1; bus.new_pc = 32'h20;
    bus.stall_if = 1'b1; bus.stall_id = 1'b1;
    bus.branch_flag = 1'b1; bus.branch_target = 32'h80;
    tick();
    idle_inputs();
    total++; if (bus.pc_o !== 32'h20 || bus.id_valid_o !== 1'b0 || bus.id_pc_o !== 32'h0 || bus.id_inst_o !== 32'h0) begin bad++;
      $display("FAIL flush_clear: got pc %h valid %b id_pc %h inst %h want 20 0 0 0", bus.pc_o, bus.id_valid_o, bus.id_pc_o, bus.id_inst_o); end
    tick();
    total++; if (bus.id_pc_o !== 32'h20 || bus.id_valid_o !== 1'b1) begin bad++;
      $display("FAIL flush_capture: got id_pc %h valid %b want 20 1", bus.id_pc_o, bus.id_valid_o); end
  endtask

  task automatic test_misaligned();
    bus.branch_flag = 1'b1; bus.branch_target = 32'h42;
    tick();
    bus.branch_flag = 1'b0;
    total++; if (bus.pc_o !== 32'h42) begin bad++; $display("FAIL adel_pc: got %h want 42", bus.pc_o); end
    tick();
    total++; if (bus.id_adel_o !== 1'b1 || bus.id_inst_o !== 32'h0 || bus.id_pc_o !== 32'h42 || bus.id_valid_o !== 1'b1) begin bad++;
      $display("FAIL adel_capture: got adel %b inst %h id_pc %h valid %b want 1 0 42 1", bus.id_adel_o, bus.id_inst_o, bus.id_pc_o, bus.id_valid_o); end
    bus.flush = 1'b1; bus.new_pc = 32'h20;
    tick();
    bus.flush = 1'b0;
    tick();
    total++; if (bus.id_adel_o !== 1'b0 || bus.id_pc_o !== 32'h20 || bus.id_inst_o !== 32'h3401_0009) begin bad++;
      $display("FAIL adel_recover: got adel %b id_pc %h inst %h want 0 20 34010009", bus.id_adel_o, bus.id_pc_o, bus.id_inst_o); end
  endtask

  task automatic test_wrap();
    bus.flush = 1'b1; bus.new_pc = 32'hFFFF_FFFC;
    tick();
    bus.flush = 1'b0;
    tick();
    total++; if (bus.pc_o !== 32'h0 || bus.id_pc_o !== 32'hFFFF_FFFC || bus.id_inst_o !== 32'h7401_0000) begin bad++;
      $display("FAIL wrap: got pc %h id_pc %h inst %h want 0 fffffffc 74010000", bus.pc_o, bus.id_pc_o, bus.id_inst_o); end
  endtask

  task automatic test_reset_mid();
    tick();
    rst = 1'b1; bus.branch_flag = 1'b1; bus.branch_target = 32'h100; bus.flush = 1'b1; bus.new_pc = 32'h200;
    tick();
    rst = 1'b0; idle_inputs();
    total++; if (bus.pc_o !== 32'h0 || bus.ce_o !== 1'b0 || bus.id_pc_o !== 32'h0 || bus.id_inst_o !== 32'h0
                 || bus.id_valid_o !== 1'b0 || bus.id_adel_o !== 1'b0) begin bad++;
      $display("FAIL reset_mid: got pc %h ce %b id_pc %h inst %h valid %b adel %b want all 0",
               bus.pc_o, bus.ce_o, bus.id_pc_o, bus.id_inst_o, bus.id_valid_o, bus.id_adel_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst              = ($urandom_range(0, 59) == 0);
      bus.flush        = ($urandom_range(0, 9) == 0);
      bus.new_pc       = $urandom() & 32'h0000_03FF;
      bus.branch_flag  = ($urandom_range(0, 3) == 0);
      bus.branch_target = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'h0000_03FF);
      bus.stall_if     = ($urandom_range(0, 4) == 0);
      bus.stall_id     = bus.stall_if ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0);
      tick();
      total++; if (bus.pc_o !== m_pc || bus.ce_o !== m_ce) begin bad++;
        $display("FAIL rnd_pc@%0d: got pc %h ce %b want %h %b", i, bus.pc_o, bus.ce_o, m_pc, m_ce); end
      total++; if (bus.id_pc_o !== m_id_pc || bus.id_inst_o !== m_id_inst) begin bad++;
        $display("FAIL rnd_id@%0d: got id_pc %h inst %h want %h %h", i, bus.id_pc_o, bus.id_inst_o, m_id_pc, m_id_inst); end
      total++; if (bus.id_valid_o !== m_id_valid || bus.id_adel_o !== m_id_adel) begin bad++;
        $display("FAIL rnd_flags@%0d: got valid %b adel %b want %b %b", i, bus.id_valid_o, bus.id_adel_o, m_id_valid, m_id_adel); end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_flush();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the MIPS32 pipeline. It owns the program counter and drives the combinational instruction ROM with pc_o and ce_o. It captures the returned word into the IF/ID pipeline register for the decode stage. It handles sequential fetch, branch redirect (with the architectural delay slot), pipeline stalls, exception flush, and misaligned-fetch detection.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and first address fetched.
PC_STEP, 4, byte increment per sequential fetch.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
stall_if  input  1  IF stage stalled; hold PC.
stall_id  input  1  ID stage stalled; hold IF/ID register.
flush  input  1  exception/eret flush from control.
new_pc  input  32  redirect target accompanying flush.
branch_flag  input  1  taken branch/jump resolved in ID this cycle.
branch_target  input  32  target for branch_flag.
inst_i  input  32  instruction word from ROM; valid in the same cycle as pc_o.
pc_o  output  32  fetch address to ROM.
ce_o  output  1  fetch enable; 0 means no valid fetch.
id_pc_o  output  32  PC of instruction held in IF/ID.
id_inst_o  output  32  instruction held in IF/ID (0 = nop bubble).
id_valid_o  output  1  IF/ID holds a real instruction.
id_adel_o  output  1  held fetch address was misaligned (AdEL).

Behaviour:
- Clocking: the single clock is clk. Reset rst is synchronous and active-high and is sampled only on the rising edge.
- Reset: pc_o=RESET_PC, ce_o=0, id_pc_o=0, id_inst_o=0, id_valid_o=0, id_adel_o=0.
- Fetch start: at the first edge with rst=0, ce_o becomes 1 and pc_o stays RESET_PC. The first real fetch is RESET_PC.
- PC update at each edge while ce_o=1, in priority order:
  1. flush=1 -> pc_o<=new_pc. This overrides both stalls.
  2. Effective IF stall -> hold pc_o. Effective IF stall is stall_if | stall_id. A branch_flag in a stalled cycle is ignored; ID reasserts it when the stall releases.
  3. branch_flag=1 -> pc_o<=branch_target.
  4. Otherwise pc_o<=pc_o+PC_STEP, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Delay slot: when branch_flag is seen, pc_o already holds branch_pc+4. That delay-slot word is latched into IF/ID on the same edge the PC redirects. No extra bubble and no squash.
- IF/ID update at each edge, in priority order:
  1. rst or flush -> clear all id_* outputs to 0.
  2. stall_id=1 -> hold all id_* outputs.
  3. stall_if=1 and stall_id=0 -> insert a bubble: id_inst_o=0, id_valid_o=0, id_adel_o=0, id_pc_o=0.
  4. Otherwise capture: id_pc_o<=pc_o; id_valid_o<=ce_o; id_adel_o<=ce_o & (pc_o[1:0]!=0); id_inst_o<=inst_i, forced to 0 when misaligned or ce_o=0.
- Illegal stall combination: stall_id=1 with stall_if=0 is not legal from control. The block treats it as both stalled: PC holds and IF/ID holds.
- Misaligned targets: misaligned branch_target/new_pc are loaded unchanged into pc_o. Detection happens at capture. Sequential fetch continues from that address until control flushes.
- Reset mid-operation: reset overrides flush, branch and stall. The next cycle behaves exactly as after power-on.
- Latency: one cycle from pc_o to the matching id_pc_o/id_inst_o. Two edges from reset release to the first id_valid_o=1.

Test Plan:
- Reset then run 4 cycles with ROM words 0x3401_0001.. -> id_pc_o sequence 0x0,0x4,0x8; id_valid_o rises on the 2nd edge after reset release.
- branch_flag=1 with target 0x40 while pc_o=0x8 -> id_pc_o=0x8 (delay slot) next cycle, then 0x40; no bubble.
- stall_if=stall_id=1 for 3 cycles at pc_o=0xC -> pc_o and IF/ID frozen; release -> fetch resumes at 0x10. stall_if=1, stall_id=0 for 1 cycle -> one id_valid_o=0 bubble.
- flush=1, new_pc=0x20, simultaneous with stall_if=stall_id=1 and branch_flag=1 -> pc_o=0x20, IF/ID cleared, next capture id_pc_o=0x20.
- branch_target=0x42 -> id_adel_o=1, id_inst_o=0, id_pc_o=0x42. Then flush to 0x20 -> id_adel_o returns to 0.
- PC at 0xFFFF_FFFC with no stall -> pc_o wraps to 0x0. Assert rst mid-run with branch_flag=1 -> pc_o=RESET_PC, ce_o=0, all id_* outputs 0.
